// File: rtl/holdoff_pulse_gen.sv
// Turns a trigger rising edge into a pulse of programmable length followed by a low holdoff gap.
// Optional: define HOLDOFF_PULSE_GEN_PENDING_EN to queue one trigger edge that arrives while busy.
module holdoff_pulse_gen #(
   parameter int CNT_W    = 8,
   parameter int DEF_HIGH = 16,
   parameter int DEF_GAP  = 4,
   parameter int DROP_W   = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              trig_in,
   input  logic [CNT_W-1:0]  high_len,
   input  logic [CNT_W-1:0]  gap_len,
   input  logic              use_default,
   output logic              pulse_out,
   output logic              busy,
   output logic              done,
   output logic [DROP_W-1:0] drop_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  DEF_H_C   = CNT_W'(DEF_HIGH);
   localparam logic [CNT_W-1:0]  DEF_G_C   = CNT_W'(DEF_GAP);
   localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};
   localparam logic [DROP_W-1:0] DROP_ONE  = {{(DROP_W-1){1'b0}}, 1'b1};

   // A zero length field falls back to the default or to a single cycle.
   function automatic logic [CNT_W-1:0] resolve_len(
      input logic [CNT_W-1:0] len,
      input logic [CNT_W-1:0] def_len,
      input logic             use_def
   );
      if (len != CNT_ZERO)
         return len;
      else if (use_def)
         return def_len;
      else
         return CNT_ONE;
   endfunction

   state_t              state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    gap_r;
   logic                trig_d_r;
   logic                pulse_r;
   logic                busy_r;
   logic                done_r;
   logic [DROP_W-1:0]   drop_r;
   logic                edge_s;
   logic                drop_s;
   logic [CNT_W-1:0]    h_res_s;
   logic [CNT_W-1:0]    g_res_s;

`ifdef HOLDOFF_PULSE_GEN_PENDING_EN
   logic                pend_r;
`endif

   // Edge detection, length resolution and the drop decision.
   always_comb begin
      edge_s  = trig_in & ~trig_d_r;
      h_res_s = resolve_len(high_len, DEF_H_C, use_default);
      g_res_s = resolve_len(gap_len, DEF_G_C, use_default);
      drop_s  = 1'b0;
      if (edge_s && (state_r != ST_IDLE)) begin
`ifdef HOLDOFF_PULSE_GEN_PENDING_EN
         drop_s = pend_r;
`else
         drop_s = 1'b1;
`endif
      end else begin
         drop_s = 1'b0;
      end
   end

   // Pulse/gap state machine with registered outputs and saturating drop counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         cnt_r    <= CNT_ZERO;
         gap_r    <= CNT_ZERO;
         trig_d_r <= 1'b0;
         pulse_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         drop_r   <= {DROP_W{1'b0}};
`ifdef HOLDOFF_PULSE_GEN_PENDING_EN
         pend_r   <= 1'b0;
`endif
      end else begin
         trig_d_r <= trig_in;
         done_r   <= 1'b0;
         if (drop_s && (drop_r != DROP_MAX))
            drop_r <= drop_r + DROP_ONE;
`ifdef HOLDOFF_PULSE_GEN_PENDING_EN
         // First busy edge is parked; gap completion below may consume it at once.
         if (edge_s && (state_r != ST_IDLE) && !pend_r)
            pend_r <= 1'b1;
`endif
         case (state_r)
            ST_IDLE: begin
               if (edge_s) begin
                  cnt_r   <= h_res_s - CNT_ONE;
                  gap_r   <= g_res_s;
                  state_r <= ST_HIGH;
                  pulse_r <= 1'b1;
                  busy_r  <= 1'b1;
               end
            end
            ST_HIGH: begin
               if (cnt_r == CNT_ZERO) begin
                  cnt_r   <= gap_r - CNT_ONE;
                  state_r <= ST_GAP;
                  pulse_r <= 1'b0;
               end else begin
                  cnt_r   <= cnt_r - CNT_ONE;
               end
            end
            ST_GAP: begin
               if (cnt_r == CNT_ZERO) begin
                  done_r <= 1'b1;
`ifdef HOLDOFF_PULSE_GEN_PENDING_EN
                  if (pend_r || edge_s) begin
                     pend_r  <= 1'b0;
                     cnt_r   <= h_res_s - CNT_ONE;
                     gap_r   <= g_res_s;
                     state_r <= ST_HIGH;
                     pulse_r <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
`else
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
`endif
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               pulse_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign pulse_out  = pulse_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign drop_count = drop_r;

endmodule
